// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the HPM sampling controller.
// Holds the sweep FSM state type and the sample record pushed into the FIFO.
package riscv_pkg;

    localparam logic [11:0] CSR_MHPM_COUNTER_3 = 12'hB03;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } hpm_smp_state_t;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
        logic        last;
    } hpm_sample_t;

endpackage

// File: rtl/hpm_sample_fifo.sv
// Synchronous FIFO for counter samples; FIFO_DEPTH must be a power of 2, at least 2.
// The head reads as all-zero while empty so idle outputs are clean.
module hpm_sample_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter type         T          = hpm_sample_t
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic push_i,
    input  T     data_i,
    output logic full_o,
    input  logic pop_i,
    output logic empty_o,
    output T     data_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    T             r_mem [FIFO_DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_empty = (r_wr == r_rd);
    assign w_push  = push_i && !w_full;
    assign w_pop   = pop_i && !w_empty;

    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign data_o  = w_empty ? T'('0) : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hpm_sample_ctrl.sv
// HPM sampling controller: sweeps selected counters through the shared CSR
// port on periodic or overflow triggers and queues {idx, value, last} samples.
module hpm_sample_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned CSR_ADDR_WIDTH   = 12,
    parameter int unsigned XLEN             = 64,
    parameter int unsigned HPM_NUM_COUNTERS = 29,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned PERIOD_WIDTH     = 32
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        csr_req_i,
    input  logic [CSR_ADDR_WIDTH-1:0]   csr_addr_i,
    input  logic                        csr_we_i,
    input  logic [XLEN-1:0]             csr_wdata_i,
    output logic [XLEN-1:0]             csr_rdata_o,
    output logic [CSR_ADDR_WIDTH-1:0]   hpm_addr_o,
    output logic                        hpm_we_o,
    output logic [XLEN-1:0]             hpm_data_o,
    input  logic [XLEN-1:0]             hpm_data_i,
    input  logic                        ovf_trig_i,
    input  logic                        cfg_en_i,
    input  logic [PERIOD_WIDTH-1:0]     cfg_period_i,
    input  logic [HPM_NUM_COUNTERS-1:0] cfg_mask_i,
    output logic                        smp_valid_o,
    input  logic                        smp_ready_i,
    output logic [4:0]                  smp_idx_o,
    output logic [XLEN-1:0]             smp_data_o,
    output logic                        smp_last_o,
    output logic                        busy_o,
    output logic [15:0]                 drop_cnt_o
);

    hpm_smp_state_t              r_state;
    logic [PERIOD_WIDTH-1:0]     r_timer;
    logic [4:0]                  r_ptr;
    logic [HPM_NUM_COUNTERS-1:0] r_mask;
    logic [15:0]                 r_drop;

    logic                        w_per_trig;
    logic                        w_trig;
    logic [4:0]                  w_bit;
    logic [HPM_NUM_COUNTERS-1:0] w_rem;
    logic                        w_last;
    logic [4:0]                  w_next_idx;
    logic [4:0]                  w_first_idx;
    logic                        w_grant;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_pop;
    logic [CSR_ADDR_WIDTH-1:0]   w_ctr_addr;
    hpm_sample_t                 w_push_smp;
    hpm_sample_t                 w_head;

    function automatic logic [4:0] lowest_idx(input logic [HPM_NUM_COUNTERS-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = HPM_NUM_COUNTERS; i > 0; i--) begin
            if (v[i-1]) begin
                idx = 5'(i + 2);
            end
        end
        return idx;
    endfunction

    assign w_per_trig = cfg_en_i && (cfg_period_i != '0) && (r_timer == PERIOD_WIDTH'(1));
    assign w_trig     = (w_per_trig || ovf_trig_i) && cfg_en_i;

    // Remaining mask with the current counter cleared; its lowest bit is the
    // next counter, and an empty remainder marks the current one as last.
    assign w_bit       = r_ptr - 5'd3;
    assign w_rem       = r_mask & ~({{(HPM_NUM_COUNTERS-1){1'b0}}, 1'b1} << w_bit);
    assign w_last      = (w_rem == '0);
    assign w_next_idx  = lowest_idx(w_rem);
    assign w_first_idx = lowest_idx(cfg_mask_i);

    assign w_grant = (r_state == READ) && cfg_en_i && !csr_req_i && !w_full;

    assign w_ctr_addr = CSR_ADDR_WIDTH'(CSR_MHPM_COUNTER_3)
                      + CSR_ADDR_WIDTH'(r_ptr) - CSR_ADDR_WIDTH'(3);

    always_comb begin
        csr_rdata_o = '0;
        hpm_addr_o  = '0;
        hpm_we_o    = 1'b0;
        hpm_data_o  = '0;
        if (csr_req_i) begin
            csr_rdata_o = hpm_data_i;
            hpm_addr_o  = csr_addr_i;
            hpm_we_o    = csr_we_i;
            hpm_data_o  = csr_wdata_i;
        end else if (r_state == READ) begin
            hpm_addr_o  = w_ctr_addr;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_timer <= '0;
        end else if (!cfg_en_i) begin
            r_timer <= cfg_period_i;
        end else if (cfg_period_i != '0) begin
            // A zero count (period enabled after the fact) reloads without firing.
            if ((r_timer == PERIOD_WIDTH'(1)) || (r_timer == '0)) begin
                r_timer <= cfg_period_i;
            end else begin
                r_timer <= r_timer - PERIOD_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_drop <= '0;
        end else if (w_trig && (r_state == READ) && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trig && (cfg_mask_i != '0)) begin
                        r_state <= READ;
                        r_mask  <= cfg_mask_i;
                        r_ptr   <= w_first_idx;
                    end
                end
                READ: begin
                    if (!cfg_en_i) begin
                        r_state <= IDLE;
                    end else if (w_grant) begin
                        r_mask <= w_rem;
                        if (w_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_ptr <= w_next_idx;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_push_smp.idx  = r_ptr;
    assign w_push_smp.data = hpm_data_i;
    assign w_push_smp.last = w_last;

    assign w_pop = !w_empty && smp_ready_i;

    hpm_sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .T          (hpm_sample_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (w_grant),
        .data_i  (w_push_smp),
        .full_o  (w_full),
        .pop_i   (w_pop),
        .empty_o (w_empty),
        .data_o  (w_head)
    );

    assign smp_valid_o = !w_empty;
    assign smp_idx_o   = w_head.idx;
    assign smp_data_o  = w_head.data;
    assign smp_last_o  = w_head.last;
    assign busy_o      = (r_state == READ);
    assign drop_cnt_o  = r_drop;

endmodule

// File: tb/tb_hpm_sample_ctrl.sv
// Scoreboard bench for hpm_sample_ctrl: directed sweeps queue expected samples,
// a negedge monitor pops and compares every accepted sample.
module tb_hpm_sample_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        csr_req_i;
    logic [11:0] csr_addr_i;
    logic        csr_we_i;
    logic [63:0] csr_wdata_i;
    logic [63:0] csr_rdata_o;
    logic [11:0] hpm_addr_o;
    logic        hpm_we_o;
    logic [63:0] hpm_data_o;
    logic [63:0] hpm_data_i;
    logic        ovf_trig_i;
    logic        cfg_en_i;
    logic [31:0] cfg_period_i;
    logic [28:0] cfg_mask_i;
    logic        smp_valid_o;
    logic        smp_ready_i;
    logic [4:0]  smp_idx_o;
    logic [63:0] smp_data_o;
    logic        smp_last_o;
    logic        busy_o;
    logic [15:0] drop_cnt_o;

    always #5 clk_i = ~clk_i;

    hpm_sample_ctrl #(
        .CSR_ADDR_WIDTH   (12),
        .XLEN             (64),
        .HPM_NUM_COUNTERS (29),
        .FIFO_DEPTH       (4),
        .PERIOD_WIDTH     (32)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .csr_req_i    (csr_req_i),
        .csr_addr_i   (csr_addr_i),
        .csr_we_i     (csr_we_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rdata_o  (csr_rdata_o),
        .hpm_addr_o   (hpm_addr_o),
        .hpm_we_o     (hpm_we_o),
        .hpm_data_o   (hpm_data_o),
        .hpm_data_i   (hpm_data_i),
        .ovf_trig_i   (ovf_trig_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_period_i (cfg_period_i),
        .cfg_mask_i   (cfg_mask_i),
        .smp_valid_o  (smp_valid_o),
        .smp_ready_i  (smp_ready_i),
        .smp_idx_o    (smp_idx_o),
        .smp_data_o   (smp_data_o),
        .smp_last_o   (smp_last_o),
        .busy_o       (busy_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    // Counter block stand-in: each CSR address reads back a unique value.
    function automatic logic [63:0] ctr_val(input logic [11:0] a);
        return {20'hC0FFE, 32'h1234_5678, a};
    endfunction

    assign hpm_data_i = ctr_val(hpm_addr_o);

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int unsigned idx, input bit last);
        exp_t e;
        e.idx  = 5'(idx);
        e.data = ctr_val(12'hB03 + 12'(idx - 3));
        e.last = last;
        return e;
    endfunction

    task automatic push_sweep(input logic [28:0] mask);
        int unsigned hi;
        hi = 0;
        for (int unsigned k = 0; k < 29; k++) if (mask[k]) hi = k;
        for (int unsigned k = 0; k < 29; k++) begin
            if (mask[k]) q.push_back(mk(k + 3, k == hi));
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (rstn_i && smp_valid_o && smp_ready_i) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample actual idx=%0d required=none", smp_idx_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("smp_idx", 64'(smp_idx_o), 64'(e.idx));
                chk("smp_data", smp_data_o, e.data);
                chk("smp_last", 64'(smp_last_o), 64'(e.last));
            end
        end
    end

    int busy_cycles = 0;
    always @(negedge clk_i) if (busy_o) busy_cycles++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn_i = 1'b0; csr_req_i = 1'b0; csr_addr_i = '0; csr_we_i = 1'b0;
        csr_wdata_i = '0; ovf_trig_i = 1'b0; cfg_en_i = 1'b0;
        cfg_period_i = '0; cfg_mask_i = '0; smp_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(smp_valid_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_drop", 64'(drop_cnt_o), 0);
        chk("rst_idx", 64'(smp_idx_o), 0);
        chk("rst_rdata", csr_rdata_o, 0);
        rstn_i = 1'b1;
        tick();

        // Periodic sampling, period 10, mask 0x7
        cfg_period_i = 10; cfg_mask_i = 29'h7; smp_ready_i = 1'b1;
        tick();
        cfg_en_i = 1'b1;
        n = 0; while (!busy_o && n < 40) begin tick(); n++; end
        chk("s1_first_trig", 64'(n), 10);
        push_sweep(29'h7);
        n = 0; while (busy_o && n < 40) begin tick(); n++; end
        chk("s1_busy_len", 64'(n), 3);
        n = 0; while (!busy_o && n < 40) begin tick(); n++; end
        chk("s1_period", 64'(n), 7);
        push_sweep(29'h7);
        n = 0; while (busy_o && n < 40) begin tick(); n++; end
        chk("s1_busy_len2", 64'(n), 3);
        cfg_en_i = 1'b0;
        repeat (3) tick();
        chk("s1_drained", 64'(q.size()), 0);

        // Core CSR access steals the port for 2 cycles at counter 4
        cfg_period_i = 0; tick();
        cfg_en_i = 1'b1; ovf_trig_i = 1'b1; busy_cycles = 0;
        tick();
        ovf_trig_i = 1'b0;
        push_sweep(29'h7);
        tick();
        chk("s2_ctr_addr", 64'(hpm_addr_o), 64'h B04);
        chk("s2_idle_rdata", csr_rdata_o, 0);
        chk("s2_idle_we", 64'(hpm_we_o), 0);
        chk("s2_idle_wdata", hpm_data_o, 0);
        csr_req_i = 1'b1; csr_addr_i = 12'h300; csr_we_i = 1'b0;
        #1;
        chk("s2_core_addr", 64'(hpm_addr_o), 64'h300);
        chk("s2_core_rdata", csr_rdata_o, ctr_val(12'h300));
        tick();
        csr_we_i = 1'b1; csr_wdata_i = 64'hDEAD_BEEF_0000_0001;
        #1;
        chk("s2_core_we", 64'(hpm_we_o), 1);
        chk("s2_core_wdata", hpm_data_o, 64'hDEAD_BEEF_0000_0001);
        tick();
        csr_req_i = 1'b0; csr_we_i = 1'b0; csr_wdata_i = '0;
        n = 0; while (busy_o && n < 20) begin tick(); n++; end
        chk("s2_busy_cycles", 64'(busy_cycles), 5);
        repeat (2) tick();
        chk("s2_drained", 64'(q.size()), 0);

        // Mask 0 trigger ignored; then single counter idx 31 on overflow
        cfg_mask_i = '0; ovf_trig_i = 1'b1;
        tick();
        ovf_trig_i = 1'b0;
        chk("s3_mask0_busy", 64'(busy_o), 0);
        chk("s3_mask0_drop", 64'(drop_cnt_o), 0);
        cfg_mask_i = 29'h1000_0000; ovf_trig_i = 1'b1;
        tick();
        ovf_trig_i = 1'b0;
        push_sweep(29'h1000_0000);
        chk("s3_not_yet", 64'(smp_valid_o), 0);
        tick();
        chk("s3_valid", 64'(smp_valid_o), 1);
        chk("s3_idx", 64'(smp_idx_o), 31);
        chk("s3_busy_done", 64'(busy_o), 0);
        repeat (2) tick();

        // Stalled consumer, all 29 counters
        smp_ready_i = 1'b0; cfg_mask_i = '1; ovf_trig_i = 1'b1;
        tick();
        ovf_trig_i = 1'b0;
        push_sweep('1);
        repeat (10) tick();
        chk("s4_stall_busy", 64'(busy_o), 1);
        chk("s4_head_idx", 64'(smp_idx_o), 3);
        chk("s4_head_data", smp_data_o, ctr_val(12'hB03));
        repeat (3) tick();
        chk("s4_head_stable", 64'(smp_idx_o), 3);
        smp_ready_i = 1'b1;
        n = 0; while (busy_o && n < 200) begin tick(); n++; end
        chk("s4_done", 64'(busy_o), 0);
        repeat (6) tick();
        chk("s4_drained", 64'(q.size()), 0);

        // Drops during READ, period 2, then saturation
        cfg_en_i = 1'b0; cfg_period_i = 2; smp_ready_i = 1'b0;
        tick();
        cfg_en_i = 1'b1;
        n = 0; while (!busy_o && n < 20) begin tick(); n++; end
        chk("s5_first_trig", 64'(n), 2);
        for (int unsigned k = 3; k <= 6; k++) q.push_back(mk(k, 1'b0));
        chk("s5_drop0", 64'(drop_cnt_o), 0);
        repeat (10) tick();
        chk("s5_drop5", 64'(drop_cnt_o), 5);
        ovf_trig_i = 1'b1;
        repeat (65529) tick();
        chk("s5_drop_fffe", 64'(drop_cnt_o), 64'hFFFE);
        tick();
        chk("s5_drop_sat", 64'(drop_cnt_o), 64'hFFFF);
        repeat (5) tick();
        chk("s5_drop_hold", 64'(drop_cnt_o), 64'hFFFF);
        cfg_en_i = 1'b0; ovf_trig_i = 1'b0;
        tick();
        chk("s5_abort_idle", 64'(busy_o), 0);
        chk("s5_fifo_kept", 64'(smp_valid_o), 1);
        smp_ready_i = 1'b1;
        repeat (8) tick();
        chk("s5_drained", 64'(q.size()), 0);

        // Reset mid-sweep, then a fresh sweep
        cfg_period_i = 0; cfg_mask_i = '1; smp_ready_i = 1'b0; cfg_en_i = 1'b1;
        tick();
        ovf_trig_i = 1'b1;
        tick();
        ovf_trig_i = 1'b0;
        repeat (6) tick();
        chk("s6_pre_busy", 64'(busy_o), 1);
        rstn_i = 1'b0;
        #1;
        chk("s6_rst_valid", 64'(smp_valid_o), 0);
        chk("s6_rst_idx", 64'(smp_idx_o), 0);
        chk("s6_rst_data", smp_data_o, 0);
        chk("s6_rst_last", 64'(smp_last_o), 0);
        chk("s6_rst_busy", 64'(busy_o), 0);
        chk("s6_rst_drop", 64'(drop_cnt_o), 0);
        chk("s6_rst_addr", 64'(hpm_addr_o), 0);
        repeat (2) tick();
        rstn_i = 1'b1; smp_ready_i = 1'b1;
        tick();
        ovf_trig_i = 1'b1;
        tick();
        ovf_trig_i = 1'b0;
        push_sweep('1);
        chk("s6_not_yet", 64'(smp_valid_o), 0);
        tick();
        chk("s6_first_idx", 64'(smp_idx_o), 3);
        n = 0; while (busy_o && n < 100) begin tick(); n++; end
        chk("s6_done", 64'(busy_o), 0);
        repeat (4) tick();
        chk("s6_drained", 64'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
